// File: rtl/factory_pkg.sv
// Shared widths, dispatcher state encoding and width helpers for the machine-core dispatch slice.
package factory_pkg;

  localparam int DESC_WIDTH   = 140;
  localparam int RESULT_WIDTH = 4;
  localparam int TOTAL_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DRAIN,
    ST_DONE
  } disp_state_e;

  // Index width that never collapses to zero bits, so single-entry ranges still get a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requesting lane at or above ptr, wrapping to lane 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && req[i] && (i >= int'(ptr))) begin
        grant_valid = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = IW'(i);
      end
    end
    // Second pass covers the wrap-around below the pointer.
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/machine_core_dispatcher.sv
// Dispatches machine descriptors round-robin onto solver cores and accumulates their press counts.
// Define DISPATCHER_STATS_EN to build per-core start-to-result cycle statistics.
module machine_core_dispatcher #(
  parameter int CORE_COUNT    = 2,
  parameter int MACHINE_COUNT = 200,
  parameter int DESC_WIDTH    = factory_pkg::DESC_WIDTH,
  parameter int RESULT_WIDTH  = factory_pkg::RESULT_WIDTH,
  parameter int TOTAL_WIDTH   = factory_pkg::TOTAL_WIDTH,
  localparam int MACH_IW      = factory_pkg::clog2_min1(MACHINE_COUNT),
  localparam int CORE_IW      = factory_pkg::clog2_min1(CORE_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 mach_in_valid,
  output logic                                 mach_in_ready,
  input  logic [DESC_WIDTH-1:0]                mach_in_data,
  input  logic [CORE_COUNT-1:0]                core_ready,
  output logic [CORE_COUNT-1:0]                core_start,
  output logic [DESC_WIDTH-1:0]                core_mach_data,
  input  logic [CORE_COUNT-1:0]                core_result_valid,
  input  logic [CORE_COUNT*RESULT_WIDTH-1:0]   core_result,
  output logic                                 tx_confirmed,
  output logic [MACH_IW-1:0]                   compute_mach,
  output logic [CORE_IW-1:0]                   core_index,
  output logic [TOTAL_WIDTH-1:0]               total_presses,
  output logic                                 total_presses_valid,
  output logic                                 total_overflow,
  output logic [31:0]                          stat_min,
  output logic [31:0]                          stat_max,
  output logic [31:0]                          stat_sum
);

  import factory_pkg::*;

  localparam int CNT_W = count_width(MACHINE_COUNT);
  localparam int SUM_W = TOTAL_WIDTH + RESULT_WIDTH + 4;
  localparam logic [TOTAL_WIDTH-1:0] TOTAL_MAX = '1;

  disp_state_e               state_q, state_d;
  logic [CORE_IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CORE_COUNT-1:0]     busy_q, busy_d;
  logic [CNT_W-1:0]          disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0]          res_cnt_q, res_cnt_d;
  logic [DESC_WIDTH-1:0]     desc_q, desc_d;
  logic [TOTAL_WIDTH-1:0]    total_q, total_d;
  logic                      ovf_q, ovf_d;
  logic                      total_valid_q, total_valid_d;

  logic [CORE_COUNT-1:0]     eligible;
  logic [CORE_COUNT-1:0]     grant;
  logic [CORE_COUNT-1:0]     counted;
  logic [CORE_IW-1:0]        grant_idx;
  logic                      grant_valid;
  logic                      dispatch;
  logic                      accept;
  logic [SUM_W-1:0]          batch_sum;
  logic [SUM_W-1:0]          wide_sum;
  logic [CNT_W-1:0]          batch_cnt;

  // A core whose result lands this cycle is still marked busy, so it cannot be re-granted yet.
  assign eligible = core_ready & ~busy_q;
  assign counted  = core_result_valid & busy_q;

  rr_arbiter #(
    .N  (CORE_COUNT),
    .IW (CORE_IW)
  ) u_rr_arbiter (
    .req         (eligible),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign dispatch       = (state_q == ST_HOLD) && grant_valid;
  assign mach_in_ready  = (state_q == ST_IDLE) && (disp_cnt_q < CNT_W'(MACHINE_COUNT));
  assign accept         = mach_in_valid && mach_in_ready;

  assign core_start     = dispatch ? grant : '0;
  assign tx_confirmed   = dispatch;
  assign core_index     = dispatch ? grant_idx : '0;
  assign compute_mach   = dispatch ? disp_cnt_q[MACH_IW-1:0] : '0;
  assign core_mach_data = desc_q;

  assign total_presses       = total_q;
  assign total_presses_valid = total_valid_q;
  assign total_overflow      = ovf_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    disp_cnt_d    = disp_cnt_q;
    desc_d        = desc_q;
    total_valid_d = 1'b0;
    busy_d        = busy_q & ~counted;
    batch_sum     = '0;
    batch_cnt     = '0;

    for (int i = 0; i < CORE_COUNT; i++) begin
      if (counted[i]) begin
        batch_sum = batch_sum + SUM_W'(core_result[i*RESULT_WIDTH +: RESULT_WIDTH]);
        batch_cnt = batch_cnt + CNT_W'(1);
      end
    end

    wide_sum  = SUM_W'(total_q) + batch_sum;
    res_cnt_d = res_cnt_q + batch_cnt;
    if (wide_sum > SUM_W'(TOTAL_MAX)) begin
      total_d = TOTAL_MAX;
      ovf_d   = 1'b1;
    end else begin
      total_d = wide_sum[TOTAL_WIDTH-1:0];
      ovf_d   = ovf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          desc_d  = mach_in_data;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (grant_valid) begin
          busy_d     = busy_d | grant;
          rr_ptr_d   = (int'(grant_idx) == CORE_COUNT - 1) ? '0 : grant_idx + CORE_IW'(1);
          disp_cnt_d = disp_cnt_q + CNT_W'(1);
          state_d    = (disp_cnt_q == CNT_W'(MACHINE_COUNT - 1)) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (res_cnt_q == CNT_W'(MACHINE_COUNT)) begin
          state_d       = ST_DONE;
          total_valid_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      busy_q        <= '0;
      disp_cnt_q    <= '0;
      res_cnt_q     <= '0;
      desc_q        <= '0;
      total_q       <= '0;
      ovf_q         <= 1'b0;
      total_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= busy_d;
      disp_cnt_q    <= disp_cnt_d;
      res_cnt_q     <= res_cnt_d;
      desc_q        <= desc_d;
      total_q       <= total_d;
      ovf_q         <= ovf_d;
      total_valid_q <= total_valid_d;
    end
  end

`ifdef DISPATCHER_STATS_EN
  logic [CORE_COUNT-1:0][31:0] lat_q, lat_d;
  logic [31:0] min_q, min_d, max_q, max_d, sum_q, sum_d;
  logic [31:0] sample;

  // Latency counts the start cycle and the result cycle, hence the +1 on sampling.
  always_comb begin
    lat_d  = lat_q;
    min_d  = min_q;
    max_d  = max_q;
    sum_d  = sum_q;
    sample = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (core_start[i]) begin
        lat_d[i] = 32'd1;
      end else if (busy_q[i]) begin
        lat_d[i] = lat_q[i] + 32'd1;
      end
      if (counted[i]) begin
        sample = lat_q[i] + 32'd1;
        if (sample < min_d) min_d = sample;
        if (sample > max_d) max_d = sample;
        sum_d = sum_d + sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lat_q <= '0;
      min_q <= 32'hFFFF_FFFF;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      lat_q <= lat_d;
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign stat_min = min_q;
  assign stat_max = max_q;
  assign stat_sum = sum_q;
`else
  assign stat_min = '0;
  assign stat_max = '0;
  assign stat_sum = '0;
`endif

endmodule

// File: tb/tb_machine_core_dispatcher.sv
// Randomized bench for machine_core_dispatcher: emulated solver cores plus a transaction-level
// reference model of the dispatch, accumulation and completion rules.
module tb_machine_core_dispatcher;
  import factory_pkg::*;

  localparam int CC   = 3;
  localparam int MC   = 6;
  localparam int DW   = 32;
  localparam int RW   = 4;
  localparam int TW   = 6;
  localparam int CIW  = clog2_min1(CC);
  localparam int MIW  = clog2_min1(MC);
  localparam int TMAX = (1 << TW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              mach_in_valid;
  logic              mach_in_ready;
  logic [DW-1:0]     mach_in_data;
  logic [CC-1:0]     core_ready;
  logic [CC-1:0]     core_start;
  logic [DW-1:0]     core_mach_data;
  logic [CC-1:0]     core_result_valid;
  logic [CC*RW-1:0]  core_result;
  logic              tx_confirmed;
  logic [MIW-1:0]    compute_mach;
  logic [CIW-1:0]    core_index;
  logic [TW-1:0]     total_presses;
  logic              total_presses_valid;
  logic              total_overflow;
  logic [31:0]       stat_min;
  logic [31:0]       stat_max;
  logic [31:0]       stat_sum;

  always #5 clk = ~clk;

  machine_core_dispatcher #(
    .CORE_COUNT    (CC),
    .MACHINE_COUNT (MC),
    .DESC_WIDTH    (DW),
    .RESULT_WIDTH  (RW),
    .TOTAL_WIDTH   (TW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .clear               (clear),
    .mach_in_valid       (mach_in_valid),
    .mach_in_ready       (mach_in_ready),
    .mach_in_data        (mach_in_data),
    .core_ready          (core_ready),
    .core_start          (core_start),
    .core_mach_data      (core_mach_data),
    .core_result_valid   (core_result_valid),
    .core_result         (core_result),
    .tx_confirmed        (tx_confirmed),
    .compute_mach        (compute_mach),
    .core_index          (core_index),
    .total_presses       (total_presses),
    .total_presses_valid (total_presses_valid),
    .total_overflow      (total_overflow),
    .stat_min            (stat_min),
    .stat_max            (stat_max),
    .stat_sum            (stat_sum)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Emulated cores: cycles left until the result pulse, and the result they will report.
  int           core_left [CC];
  logic [RW-1:0] core_res [CC];

  // Reference model of the dispatcher.
  bit           m_busy [CC];
  int           m_start [CC];
  int           m_ptr, m_disp, m_res, m_total, last_res_cycle, pulses;
  bit           m_pending, m_ovf;
  logic [DW-1:0] m_desc;
  logic [31:0]  s_min, s_max, s_sum;

  int  cfg_ready_pct;
  bit  cfg_stray, cfg_block0, cfg_max;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < CC; k++) begin
      m_busy[k]  = 1'b0;
      m_start[k] = 0;
    end
    m_ptr = 0; m_disp = 0; m_res = 0; m_total = 0; m_ovf = 1'b0;
    m_pending = 1'b0; m_desc = '0; last_res_cycle = -100; pulses = 0;
    s_min = 32'hFFFF_FFFF; s_max = '0; s_sum = '0;
  endtask

  task automatic applyStimulus(input bit do_rst, input bit do_clr);
    reset         = do_rst;
    clear         = do_clr;
    mach_in_valid = ($urandom_range(0, 99) < 70);
    mach_in_data  = $urandom();
    for (int k = 0; k < CC; k++) begin
      core_ready[k] = !(do_rst || do_clr) && (core_left[k] == 0) &&
                      ($urandom_range(0, 99) < cfg_ready_pct) && !(cfg_block0 && k == 0);
      core_result_valid[k] = 1'b0;
      core_result[k*RW +: RW] = RW'($urandom_range(0, 15));
      if (core_left[k] == 1) begin
        core_result_valid[k] = 1'b1;
        core_result[k*RW +: RW] = core_res[k];
      end else if (core_left[k] == 0 && cfg_stray && $urandom_range(0, 99) < 10) begin
        core_result_valid[k] = 1'b1;
      end
    end
  endtask

  task automatic checkCycle(output int exp_k);
    int k;
    exp_k = -1;
    k = 0;
    if (m_pending) begin
      for (int i = 0; i < CC; i++) begin
        k = (m_ptr + i) % CC;
        if (exp_k < 0 && core_ready[k] && !m_busy[k]) exp_k = k;
      end
    end
    checkOutput("core_start", 64'(core_start), (exp_k >= 0) ? (64'd1 << exp_k) : 64'd0);
    checkOutput("tx_confirmed", 64'(tx_confirmed), 64'(exp_k >= 0));
    checkOutput("mach_in_ready", 64'(mach_in_ready), 64'(!m_pending && m_disp < MC));
    checkOutput("total_presses", 64'(total_presses), 64'(m_total));
    checkOutput("total_overflow", 64'(total_overflow), 64'(m_ovf));
    checkOutput("total_valid", 64'(total_presses_valid), 64'(cycle == last_res_cycle + 2));
    if (exp_k >= 0) begin
      checkOutput("core_index", 64'(core_index), 64'(exp_k));
      checkOutput("compute_mach", 64'(compute_mach), 64'(m_disp));
      checkOutput("core_mach_data", 64'(core_mach_data), 64'(m_desc));
    end
    if (total_presses_valid) pulses++;
  endtask

  task automatic updateModel(input int exp_k);
    logic [31:0] lat;
    for (int k = 0; k < CC; k++) begin
      if (core_result_valid[k] && m_busy[k]) begin
        m_total += int'(core_result[k*RW +: RW]);
        m_res++;
        m_busy[k] = 1'b0;
        lat = 32'(cycle - m_start[k] + 1);
        if (lat < s_min) s_min = lat;
        if (lat > s_max) s_max = lat;
        s_sum += lat;
        if (m_res == MC) last_res_cycle = cycle;
      end
    end
    if (m_total > TMAX) begin
      m_total = TMAX;
      m_ovf   = 1'b1;
    end
    if (exp_k >= 0) begin
      m_busy[exp_k]  = 1'b1;
      m_start[exp_k] = cycle;
      m_ptr          = (exp_k + 1) % CC;
      m_disp++;
      m_pending      = 1'b0;
    end else if (mach_in_valid && !m_pending && m_disp < MC) begin
      m_pending = 1'b1;
      m_desc    = mach_in_data;
    end
  endtask

  task automatic stepCycle(input bit do_rst, input bit do_clr);
    int exp_k;
    exp_k = -1;
    applyStimulus(do_rst, do_clr);
    @(negedge clk);
    if (!(do_rst || do_clr)) begin
      checkCycle(exp_k);
      updateModel(exp_k);
    end
    for (int k = 0; k < CC; k++) begin
      if (core_left[k] > 0) core_left[k]--;
      if (core_start[k] && !(do_rst || do_clr)) begin
        core_left[k] = $urandom_range(1, 7);
        core_res[k]  = cfg_max ? RW'(15) : RW'($urandom_range(0, 15));
      end
    end
    if (do_rst || do_clr) resetModel();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic runMachines(input string name, input int ready_pct, input bit stray,
                             input bit block0, input bit max_res, input bit abort);
    int  budget;
    bit  aborted;
    cfg_ready_pct = ready_pct;
    cfg_stray     = stray;
    cfg_block0    = block0;
    cfg_max       = max_res;
    budget        = 0;
    aborted       = 1'b0;
    stepCycle(1'b0, 1'b1);
    while (!(last_res_cycle >= 0 && cycle > last_res_cycle + 4) && budget < 3000) begin
      if (abort && !aborted && m_pending && m_disp >= 2) begin
        stepCycle(1'b1, 1'b0);
        aborted = 1'b1;
      end else begin
        stepCycle(1'b0, 1'b0);
      end
      budget++;
    end
    if (budget >= 3000) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
    checkOutput({name, "_valid_pulses"}, 64'(pulses), 64'd1);
    checkOutput({name, "_final_total"}, 64'(total_presses), 64'(m_total));
    checkOutput({name, "_final_overflow"}, 64'(total_overflow), 64'(m_ovf));
`ifdef DISPATCHER_STATS_EN
    checkOutput({name, "_stat_min"}, 64'(stat_min), 64'(s_min));
    checkOutput({name, "_stat_max"}, 64'(stat_max), 64'(s_max));
    checkOutput({name, "_stat_sum"}, 64'(stat_sum), 64'(s_sum));
`else
    checkOutput({name, "_stat_zero"}, 64'({stat_min, stat_max} | 64'(stat_sum)), 64'd0);
`endif
    $display("[TB] run %s done: total=%0d overflow=%0d", name, m_total, m_ovf);
  endtask

  initial begin
    for (int k = 0; k < CC; k++) begin
      core_left[k] = 0;
      core_res[k]  = '0;
    end
    resetModel();
    cfg_ready_pct = 100; cfg_stray = 1'b0; cfg_block0 = 1'b0; cfg_max = 1'b0;
    reset = 1'b1; clear = 1'b0; mach_in_valid = 1'b0; mach_in_data = '0;
    core_ready = '0; core_result_valid = '0; core_result = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 64'(mach_in_ready), 64'd1);
    checkOutput("rst_core_start", 64'(core_start), 64'd0);
    checkOutput("rst_tx", 64'(tx_confirmed), 64'd0);
    checkOutput("rst_total", 64'(total_presses), 64'd0);
    checkOutput("rst_overflow", 64'(total_overflow), 64'd0);
    checkOutput("rst_valid", 64'(total_presses_valid), 64'd0);
`ifdef DISPATCHER_STATS_EN
    checkOutput("rst_stat_min", 64'(stat_min), 64'h0000_0000_FFFF_FFFF);
`else
    checkOutput("rst_stat_min", 64'(stat_min), 64'd0);
`endif
    checkOutput("rst_stat_sum", 64'(stat_sum), 64'd0);
    @(posedge clk);
    #1;
    cycle++;

    runMachines("all_ready", 100, 1'b0, 1'b0, 1'b0, 1'b0);
    runMachines("sparse_ready", 40, 1'b1, 1'b0, 1'b0, 1'b0);
    runMachines("core0_blocked", 80, 1'b0, 1'b1, 1'b0, 1'b0);
    runMachines("saturate", 100, 1'b0, 1'b0, 1'b1, 1'b0);
    runMachines("abort_in_hold", 100, 1'b1, 1'b0, 1'b0, 1'b1);
    runMachines("random_mix", 60, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
